// File: rtl/inst_fetch_bus.sv
// Instruction-side bus master: issues one read per PC, returns the word to IF/ID
// and holds a captured word while the pipeline is stalled downstream.
module inst_fetch_bus #(
    parameter int STARTUP_CYCLES = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          IF_PC,
    input  logic                 ID_Hold,
    input  logic [31:0]          InstMem_In,
    input  logic                 InstMem_Ready,
    output logic [29:0]          InstMem_Address,
    output logic                 InstMem_Read,
    output logic [31:0]          IF_Instruction,
    output logic                 Inst_Stall,
    output logic                 Startup_Stall,
    output logic [CNT_WIDTH-1:0] Inst_Stall_Count
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int SC_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SC_W-1:0] STARTUP_LAST =
        SC_W'((STARTUP_CYCLES > 0) ? (STARTUP_CYCLES - 1) : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state_reg;
    state_t                 reset_state;
    logic [SC_W-1:0]        startup_cnt_reg;
    logic [31:0]            buffer_reg;
    logic [CNT_WIDTH-1:0]   stall_cnt_reg;

    logic                   in_startup;
    logic                   in_wait;
    logic                   in_held;
    logic                   wait_ack;

    // With no startup interval the block comes out of reset already fetching.
    generate
        if (STARTUP_CYCLES == 0) begin : g_no_startup
            assign reset_state = ST_WAIT;
        end else begin : g_startup
            assign reset_state = ST_STARTUP;
        end
    endgenerate

    assign in_startup = (state_reg == ST_STARTUP);
    assign in_wait    = (state_reg == ST_WAIT);
    assign in_held    = (state_reg == ST_HELD);
    assign wait_ack   = in_wait & InstMem_Ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= reset_state;
            startup_cnt_reg <= '0;
            buffer_reg      <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_STARTUP: begin
                    startup_cnt_reg <= startup_cnt_reg + 1'b1;
                    if (startup_cnt_reg == STARTUP_LAST) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (InstMem_Ready) begin
                        // A word arriving under a downstream hold is parked so the
                        // read is not repeated once the hold clears.
                        if (ID_Hold) begin
                            buffer_reg <= InstMem_In;
                            state_reg  <= ST_HELD;
                        end
                    end else if (stall_cnt_reg != CNT_MAX) begin
                        stall_cnt_reg <= stall_cnt_reg + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!ID_Hold) begin
                        state_reg <= ST_WAIT;
                    end
                end
                default: begin
                    state_reg <= reset_state;
                end
            endcase
        end
    end

    assign InstMem_Address  = IF_PC[31:2];
    assign InstMem_Read     = in_wait;
    assign Inst_Stall       = in_wait & ~InstMem_Ready;
    assign Startup_Stall    = in_startup;
    assign Inst_Stall_Count = stall_cnt_reg;

    always_comb begin
        IF_Instruction = '0;
        if (wait_ack) begin
            IF_Instruction = InstMem_In;
        end else if (in_wait || in_held) begin
            IF_Instruction = buffer_reg;
        end
    end

`ifndef SYNTHESIS
    a_stall_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(Startup_Stall && Inst_Stall));

    a_pc_aligned: assert property (@(posedge clock) disable iff (reset)
        InstMem_Read |-> (IF_PC[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_inst_fetch_bus.sv
// Directed bench for inst_fetch_bus: startup, zero-wait, latency, hold,
// spurious acknowledge and mid-fetch reset, plus a zero-startup instance.
module tb_inst_fetch_bus;

    logic        clock;
    logic        reset;
    logic [31:0] if_pc;
    logic        id_hold;
    logic [31:0] mem_in;
    logic        mem_ready;

    logic [29:0] addr0, addr1;
    logic        read0, read1;
    logic [31:0] inst0, inst1;
    logic        stall0, stall1;
    logic        sstall0, sstall1;
    logic [31:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    inst_fetch_bus #(.STARTUP_CYCLES(4), .CNT_WIDTH(32)) dut0 (
        .clock            (clock),
        .reset            (reset),
        .IF_PC            (if_pc),
        .ID_Hold          (id_hold),
        .InstMem_In       (mem_in),
        .InstMem_Ready    (mem_ready),
        .InstMem_Address  (addr0),
        .InstMem_Read     (read0),
        .IF_Instruction   (inst0),
        .Inst_Stall       (stall0),
        .Startup_Stall    (sstall0),
        .Inst_Stall_Count (cnt0)
    );

    inst_fetch_bus #(.STARTUP_CYCLES(0), .CNT_WIDTH(32)) dut1 (
        .clock            (clock),
        .reset            (reset),
        .IF_PC            (if_pc),
        .ID_Hold          (id_hold),
        .InstMem_In       (mem_in),
        .InstMem_Ready    (mem_ready),
        .InstMem_Address  (addr1),
        .InstMem_Read     (read1),
        .IF_Instruction   (inst1),
        .Inst_Stall       (stall1),
        .Startup_Stall    (sstall1),
        .Inst_Stall_Count (cnt1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    // and outputs are sampled a few ns later, well before the next edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic show();
        $display("cyc %0d pc=%h rdy=%b hold=%b | rd=%b addr=%h inst=%h stall=%b sstall=%b cnt=%0d",
                 cyc, if_pc, mem_ready, id_hold, read0, addr0, inst0, stall0, sstall0, cnt0);
    endtask

    initial begin
        reset     = 1'b1;
        if_pc     = 32'h0;
        id_hold   = 1'b0;
        mem_in    = 32'h0;
        mem_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        cyc = 0;

        // cycle 0: first cycle after reset release
        reset = 1'b0;
        #3; show();
        check_eq("startup_c0",   {31'd0, sstall0}, 32'd1);
        check_eq("read_c0",      {31'd0, read0},   32'd0);
        check_eq("inst_c0",      inst0,            32'd0);
        check_eq("stall_c0",     {31'd0, stall0},  32'd0);
        check_eq("cnt_reset",    cnt0,             32'd0);
        check_eq("z_read_c0",    {31'd0, read1},   32'd1);
        check_eq("z_startup_c0", {31'd0, sstall1}, 32'd0);

        // cycle 1: spurious acknowledge during startup
        next_cycle();
        mem_ready = 1'b1; mem_in = 32'h1234_5678;
        #3; show();
        check_eq("startup_c1",   {31'd0, sstall0}, 32'd1);
        check_eq("spur_st_read", {31'd0, read0},   32'd0);
        check_eq("spur_st_inst", inst0,            32'd0);

        next_cycle();
        mem_ready = 1'b0; mem_in = 32'h0;
        #3; show();
        check_eq("startup_c2", {31'd0, sstall0}, 32'd1);

        next_cycle();
        #3; show();
        check_eq("startup_c3", {31'd0, sstall0}, 32'd1);
        check_eq("read_c3",    {31'd0, read0},   32'd0);

        // cycles 4-6: zero-wait fetches
        next_cycle();
        if_pc = 32'h0; mem_ready = 1'b1; mem_in = 32'h2408_0001;
        #3; show();
        check_eq("startup_c4", {31'd0, sstall0}, 32'd0);
        check_eq("read_c4",    {31'd0, read0},   32'd1);
        check_eq("addr_pc0",   {2'd0, addr0},    32'd0);
        check_eq("inst_pc0",   inst0,            32'h2408_0001);
        check_eq("stall_pc0",  {31'd0, stall0},  32'd0);

        next_cycle();
        if_pc = 32'h4; mem_in = 32'h2409_0002;
        #3; show();
        check_eq("addr_pc4",  {2'd0, addr0},   32'd1);
        check_eq("inst_pc4",  inst0,           32'h2409_0002);
        check_eq("stall_pc4", {31'd0, stall0}, 32'd0);

        next_cycle();
        if_pc = 32'h8; mem_in = 32'h0109_5020;
        #3; show();
        check_eq("addr_pc8",  {2'd0, addr0},   32'd2);
        check_eq("inst_pc8",  inst0,           32'h0109_5020);
        check_eq("stall_pc8", {31'd0, stall0}, 32'd0);
        check_eq("cnt_zw",    cnt0,            32'd0);

        // cycles 7-10: three-cycle latency at 0x100
        next_cycle();
        if_pc = 32'h100; mem_ready = 1'b0; mem_in = 32'h0;
        #3; show();
        check_eq("lat_stall1", {31'd0, stall0}, 32'd1);
        check_eq("lat_addr",   {2'd0, addr0},   32'h40);

        next_cycle();
        #3; show();
        check_eq("lat_stall2", {31'd0, stall0}, 32'd1);

        next_cycle();
        #3; show();
        check_eq("lat_stall3", {31'd0, stall0}, 32'd1);
        check_eq("lat_addr3",  {2'd0, addr0},   32'h40);
        check_eq("lat_cnt2",   cnt0,            32'd2);

        next_cycle();
        mem_ready = 1'b1; mem_in = 32'hCAFE_F00D;
        #3; show();
        check_eq("lat_stall_rdy", {31'd0, stall0}, 32'd0);
        check_eq("lat_inst",      inst0,           32'hCAFE_F00D);
        check_eq("lat_cnt",       cnt0,            32'd3);

        // cycle 11: word arrives under hold
        next_cycle();
        if_pc = 32'h104; mem_in = 32'hDEAD_BEEF; id_hold = 1'b1;
        #3; show();
        check_eq("hold_inst_ack", inst0,          32'hDEAD_BEEF);
        check_eq("hold_read_ack", {31'd0, read0}, 32'd1);

        // cycle 12: HELD with a spurious acknowledge
        next_cycle();
        mem_ready = 1'b1; mem_in = 32'h1111_1111;
        #3; show();
        check_eq("held_read",  {31'd0, read0},  32'd0);
        check_eq("held_inst",  inst0,           32'hDEAD_BEEF);
        check_eq("held_stall", {31'd0, stall0}, 32'd0);

        next_cycle();
        mem_ready = 1'b0; mem_in = 32'h0;
        #3; show();
        check_eq("held_inst2", inst0,          32'hDEAD_BEEF);
        check_eq("held_read2", {31'd0, read0}, 32'd0);

        // cycle 14: hold released; buffered word consumed at this edge
        next_cycle();
        id_hold = 1'b0;
        #3; show();
        check_eq("rel_read", {31'd0, read0}, 32'd0);
        check_eq("rel_inst", inst0,          32'hDEAD_BEEF);
        check_eq("held_cnt", cnt0,           32'd3);

        // cycles 15-16: exactly one new read for PC+4
        next_cycle();
        if_pc = 32'h108;
        #3; show();
        check_eq("next_read",  {31'd0, read0},  32'd1);
        check_eq("next_addr",  {2'd0, addr0},   32'h42);
        check_eq("next_stall", {31'd0, stall0}, 32'd1);

        next_cycle();
        mem_ready = 1'b1; mem_in = 32'h0109_5020;
        #3; show();
        check_eq("next_inst", inst0, 32'h0109_5020);
        check_eq("next_cnt",  cnt0,  32'd4);

        // cycle 17: reset while a read is outstanding
        next_cycle();
        if_pc = 32'h10C; mem_ready = 1'b0; mem_in = 32'h0; reset = 1'b1;
        #3; show();
        check_eq("pre_rst_read", {31'd0, read0}, 32'd1);

        next_cycle();
        reset = 1'b0;
        #3; show();
        check_eq("rst_read",     {31'd0, read0},   32'd0);
        check_eq("rst_startup",  {31'd0, sstall0}, 32'd1);
        check_eq("rst_cnt",      cnt0,             32'd0);
        check_eq("rst_inst",     inst0,            32'd0);
        check_eq("rst_stall",    {31'd0, stall0},  32'd0);
        check_eq("z_rst_read",   {31'd0, read1},   32'd1);
        check_eq("z_rst_startup",{31'd0, sstall1}, 32'd0);
        check_eq("z_rst_cnt",    cnt1,             32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cycle %0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch_bus.md
Name: inst_fetch_bus

Overview:
Instruction-side bus master for the MIPS32 core. It issues instruction reads for the current PC and returns the fetched word to the IF/ID boundary. It generates the Startup_Stall and Inst_Stall terms that the hazard/stall unit folds into IF_Stall, and consumes that unit's downstream hold indication. It holds a fetched word while the pipeline is stalled, so no fetch is lost or repeated.

Parameters:
STARTUP_CYCLES, 4, number of cycles after reset release during which Startup_Stall is held and no fetch is issued; 0 means no startup delay.
CNT_WIDTH, 32, width of the saturating Inst_Stall cycle counter.

Ports:
clock  in  1  core clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
IF_PC  in  32  byte address of the instruction to fetch; stable whenever Inst_Stall=1 or ID_Hold=1.
ID_Hold  in  1  IF/ID must not advance for reasons other than this block (data hazard, exception, ALU or data-memory stall); must not depend combinationally on Inst_Stall or Startup_Stall.
InstMem_In  in  32  read data, valid only when InstMem_Ready=1.
InstMem_Ready  in  1  one-cycle acknowledge for the outstanding read.
InstMem_Address  out  30  word address = IF_PC[31:2].
InstMem_Read  out  1  read request, level-held until acknowledged.
IF_Instruction  out  32  instruction presented to IF/ID.
Inst_Stall  out  1  fetch for current PC not yet returned.
Startup_Stall  out  1  post-reset startup interval active.
Inst_Stall_Count  out  CNT_WIDTH  saturating count of cycles with Inst_Stall=1.

Behaviour:
- States: STARTUP, WAIT, HELD. Reset forces STARTUP, startup counter=0, buffer=0, Inst_Stall_Count=0.
- Reset values: InstMem_Read=0, Inst_Stall=0, Startup_Stall=1 (0 if STARTUP_CYCLES=0), IF_Instruction=0.
- STARTUP:
  - Startup_Stall=1, InstMem_Read=0, Inst_Stall=0, IF_Instruction=0 (NOP).
  - Counter increments each cycle; after STARTUP_CYCLES cycles in STARTUP the state moves to WAIT.
  - STARTUP_CYCLES=0: WAIT is entered on the first cycle after reset, and Startup_Stall is never asserted.
- WAIT:
  - InstMem_Read=1; InstMem_Address tracks IF_PC combinationally.
  - Inst_Stall = ~InstMem_Ready. This combinational path is intentional and gives zero-wait fetches.
  - IF_Instruction = InstMem_In when Ready=1, else the buffer.
  - Ready & ~ID_Hold: word consumed; stay in WAIT. PC advances at this edge, so Read stays high for the next address. Sustained throughput is 1 instruction/cycle.
  - Ready & ID_Hold: capture InstMem_In into the buffer and go to HELD.
  - ~Ready: remain in WAIT; Inst_Stall_Count += 1, saturating at all-ones.
- HELD:
  - InstMem_Read=0, Inst_Stall=0, IF_Instruction=buffer.
  - ~ID_Hold: go to WAIT, where the next read issues for the advanced PC. The buffered word is consumed at this edge.
  - ID_Hold: remain in HELD.
- InstMem_Ready outside WAIT is ignored: no capture, no state change.
- At most one read is outstanding; the bus must not return Ready before Read is sampled high.
- Reset mid-fetch (WAIT or HELD): next state STARTUP, Read drops the following cycle, and the buffered word is discarded. The instruction memory shares this reset, so a late Ready cannot occur.
- Startup_Stall and Inst_Stall are never both 1.

Test Plan:
- STARTUP_CYCLES=4, reset released at cycle 0 → Startup_Stall=1 in cycles 0-3, InstMem_Read=1 from cycle 4, IF_Instruction=0 throughout startup.
- Zero-wait memory, ID_Hold=0, PC 0x0,0x4,0x8 with words 0x24080001,0x24090002,0x01095020 → one word per cycle, InstMem_Address 0,1,2, Inst_Stall never 1, Inst_Stall_Count=0.
- 3-cycle memory latency at PC 0x100 → Inst_Stall=1 for 3 cycles, Address held at 0x40, word appears on the Ready cycle, Inst_Stall_Count=3.
- Ready with ID_Hold=1 for 2 cycles, word 0xDEADBEEF → HELD, Read=0, IF_Instruction=0xDEADBEEF stable; ID_Hold falls → exactly one new read at PC+4, and the word is never re-fetched.
- Spurious InstMem_Ready pulse in STARTUP and in HELD → no output or state change.
- Reset asserted while in WAIT with Read=1 → next cycle Read=0, Startup_Stall=1, count cleared; STARTUP_CYCLES=0 variant → Read=1 on the first post-reset cycle.
